// File: rtl/game_controller.sv
// rtl/game_controller.sv - Space Invaders game-state sequencer (formation, ship, bullet, status)
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   tick              one-cycle game-step strobe, accepted only when idle and playing
//   btn_left/right    ship move requests (levels, sampled once per tick)
//   btn_fire          fire request; a rising edge is latched until the next tick
//   invaders_array    live invaders per grid column (bit i = column i)
//   invaders_line     grid row of the formation
//   ship_x            ship column 0..19
//   bullet_x/_y       bullet column/row, bullet_flying marks it active
//   gameplay          00 playing, 01 you win, 10 game over
//   busy              high while the per-tick update sequence runs
module game_controller #(
    parameter int          SHIP_ROW   = 13,
    parameter int          SHIP_START = 10,
    parameter logic [19:0] INV_INIT   = 20'h0FFF0,
    parameter int          INV_PERIOD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_fire,
    output logic [19:0] invaders_array,
    output logic [3:0]  invaders_line,
    output logic [4:0]  ship_x,
    output logic [4:0]  bullet_x,
    output logic [3:0]  bullet_y,
    output logic        bullet_flying,
    output logic [1:0]  gameplay,
    output logic        busy
);

    localparam logic [1:0] GP_PLAYING = 2'b00;
    localparam logic [1:0] GP_WIN     = 2'b01;
    localparam logic [1:0] GP_OVER    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIP,
        S_BULLET,
        S_HIT1,
        S_INV,
        S_HIT2,
        S_CHECK
    } state_t;

    state_t     state;
    logic       dir_left;
    logic [3:0] inv_count;
    logic       fire_q;
    logic       fire_q2;
    logic       fire_pending;
    logic       fire_edge;
    logic       hit;

    assign fire_edge = fire_q & ~fire_q2;

    // The bullet kills the invader it overlaps; bullet_x never exceeds 19.
    assign hit = bullet_flying && (bullet_y == invaders_line) && invaders_array[bullet_x];

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            invaders_array <= INV_INIT;
            invaders_line  <= 4'd0;
            ship_x         <= 5'(SHIP_START);
            bullet_x       <= 5'd0;
            bullet_y       <= 4'd0;
            bullet_flying  <= 1'b0;
            gameplay       <= GP_PLAYING;
            dir_left       <= 1'b0;
            inv_count      <= 4'd0;
            fire_q         <= 1'b0;
            fire_q2        <= 1'b0;
            fire_pending   <= 1'b0;
        end else begin
            fire_q  <= btn_fire;
            fire_q2 <= fire_q;

            // BULLET owns fire_pending in its own cycle; elsewhere an edge just sets it.
            // Once the game has ended the latch is frozen along with everything else.
            if (gameplay == GP_PLAYING && fire_edge && state != S_BULLET)
                fire_pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (tick && gameplay == GP_PLAYING) begin
                        state <= S_SHIP;
                        busy  <= 1'b1;
                    end
                end

                S_SHIP: begin
                    if (btn_left && !btn_right && ship_x != 5'd0)
                        ship_x <= ship_x - 5'd1;
                    else if (btn_right && !btn_left && ship_x != 5'd19)
                        ship_x <= ship_x + 5'd1;
                    state <= S_BULLET;
                end

                S_BULLET: begin
                    // Clears the latch unless a new edge lands in this very cycle.
                    fire_pending <= fire_edge;
                    if (bullet_flying && bullet_y == 4'd0) begin
                        bullet_flying <= 1'b0;
                    end else if (bullet_flying) begin
                        bullet_y <= bullet_y - 4'd1;
                    end else if (fire_pending) begin
                        bullet_flying <= 1'b1;
                        bullet_x      <= ship_x;
                        bullet_y      <= 4'(SHIP_ROW - 1);
                    end
                    state <= S_HIT1;
                end

                S_HIT1, S_HIT2: begin
                    if (hit) begin
                        invaders_array[bullet_x] <= 1'b0;
                        bullet_flying            <= 1'b0;
                    end
                    state <= (state == S_HIT1) ? S_INV : S_CHECK;
                end

                S_INV: begin
                    if (inv_count == 4'(INV_PERIOD - 1)) begin
                        inv_count <= 4'd0;
                        if (!dir_left) begin
                            if (invaders_array[19]) begin
                                invaders_line <= invaders_line + 4'd1;
                                dir_left      <= 1'b1;
                            end else begin
                                invaders_array <= invaders_array << 1;
                            end
                        end else begin
                            if (invaders_array[0]) begin
                                invaders_line <= invaders_line + 4'd1;
                                dir_left      <= 1'b0;
                            end else begin
                                invaders_array <= invaders_array >> 1;
                            end
                        end
                    end else begin
                        inv_count <= inv_count + 4'd1;
                    end
                    state <= S_HIT2;
                end

                S_CHECK: begin
                    // A cleared formation wins even if it also reached the ship row.
                    if (invaders_array == 20'd0)
                        gameplay <= GP_WIN;
                    else if (invaders_line >= 4'(SHIP_ROW))
                        gameplay <= GP_OVER;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - directed self-checking bench for game_controller
module tb_game_controller;

    logic        clk;
    logic        reset;
    logic [2:0]  tick;
    logic [2:0]  btn_left;
    logic [2:0]  btn_right;
    logic [2:0]  btn_fire;
    logic [19:0] inv_arr   [3];
    logic [3:0]  inv_line  [3];
    logic [4:0]  ship_x    [3];
    logic [4:0]  bullet_x  [3];
    logic [3:0]  bullet_y  [3];
    logic [2:0]  flying;
    logic [1:0]  gameplay  [3];
    logic [2:0]  busy;

    int checks;
    int failures;

    // A: default formation, slow invaders (ship clamp, shoot and hit)
    game_controller #(.SHIP_ROW(13), .SHIP_START(10), .INV_INIT(20'h0FFF0), .INV_PERIOD(15)) u_a (
        .clk(clk), .reset(reset), .tick(tick[0]),
        .btn_left(btn_left[0]), .btn_right(btn_right[0]), .btn_fire(btn_fire[0]),
        .invaders_array(inv_arr[0]), .invaders_line(inv_line[0]), .ship_x(ship_x[0]),
        .bullet_x(bullet_x[0]), .bullet_y(bullet_y[0]), .bullet_flying(flying[0]),
        .gameplay(gameplay[0]), .busy(busy[0])
    );

    // B: single invader at column 10 (miss, refire discard, win)
    game_controller #(.SHIP_ROW(13), .SHIP_START(10), .INV_INIT(20'h00400), .INV_PERIOD(15)) u_b (
        .clk(clk), .reset(reset), .tick(tick[1]),
        .btn_left(btn_left[1]), .btn_right(btn_right[1]), .btn_fire(btn_fire[1]),
        .invaders_array(inv_arr[1]), .invaders_line(inv_line[1]), .ship_x(ship_x[1]),
        .bullet_x(bullet_x[1]), .bullet_y(bullet_y[1]), .bullet_flying(flying[1]),
        .gameplay(gameplay[1]), .busy(busy[1])
    );

    // C: single invader at column 19, step every tick (edge drop, game over)
    game_controller #(.SHIP_ROW(13), .SHIP_START(10), .INV_INIT(20'h80000), .INV_PERIOD(1)) u_c (
        .clk(clk), .reset(reset), .tick(tick[2]),
        .btn_left(btn_left[2]), .btn_right(btn_right[2]), .btn_fire(btn_fire[2]),
        .invaders_array(inv_arr[2]), .invaders_line(inv_line[2]), .ship_x(ship_x[2]),
        .bullet_x(bullet_x[2]), .bullet_y(bullet_y[2]), .bullet_flying(flying[2]),
        .gameplay(gameplay[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One tick pulse; returns how many consecutive cycles busy stayed high.
    task automatic do_tick(input int i, output int cyc);
        @(negedge clk);
        tick[i] = 1'b1;
        @(negedge clk);
        tick[i] = 1'b0;
        cyc = 0;
        while (busy[i] && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic press_fire(input int i);
        @(negedge clk);
        btn_fire[i] = 1'b1;
        repeat (3) @(negedge clk);
        btn_fire[i] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cyc;
        int n;
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        tick      = 3'b000;
        btn_left  = 3'b000;
        btn_right = 3'b000;
        btn_fire  = 3'b000;

        // 1. reset state
        do_reset();
        check("rst_a_array", 32'(inv_arr[0]), 32'h0FFF0);
        check("rst_a_line", 32'(inv_line[0]), 0);
        check("rst_a_ship", 32'(ship_x[0]), 10);
        check("rst_a_bx", 32'(bullet_x[0]), 0);
        check("rst_a_by", 32'(bullet_y[0]), 0);
        check("rst_a_fly", 32'(flying[0]), 0);
        check("rst_a_gp", 32'(gameplay[0]), 0);
        check("rst_a_busy", 32'(busy[0]), 0);
        check("rst_b_array", 32'(inv_arr[1]), 32'h00400);
        check("rst_c_array", 32'(inv_arr[2]), 32'h80000);

        // 2. ship clamps at column 0; busy lasts 6 cycles per tick
        btn_left[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            do_tick(0, cyc);
            check("clamp_ship", 32'(ship_x[0]), (k < 10) ? 10 - k : 0);
            check("clamp_busy_cycles", 32'(cyc), 6);
        end
        btn_left[0]  = 1'b0;
        btn_right[0] = 1'b1;
        // second tick arrives while busy and must be dropped
        @(negedge clk);
        tick[0] = 1'b1;
        @(negedge clk);
        tick[0] = 1'b0;
        @(negedge clk);
        tick[0] = 1'b1;
        @(negedge clk);
        tick[0] = 1'b0;
        repeat (10) @(negedge clk);
        btn_right[0] = 1'b0;
        check("busy_drop_ship", 32'(ship_x[0]), 1);
        check("busy_drop_idle", 32'(busy[0]), 0);

        // 3. shoot and hit column 10
        do_reset();
        press_fire(0);
        do_tick(0, cyc);
        check("shot_fly", 32'(flying[0]), 1);
        check("shot_x", 32'(bullet_x[0]), 10);
        check("shot_y", 32'(bullet_y[0]), 12);
        for (int k = 2; k <= 12; k++) begin
            do_tick(0, cyc);
            check("shot_climb_y", 32'(bullet_y[0]), 13 - k);
            check("shot_climb_fly", 32'(flying[0]), 1);
        end
        do_tick(0, cyc);
        check("hit_array", 32'(inv_arr[0]), 32'h0FBF0);
        check("hit_fly", 32'(flying[0]), 0);
        check("hit_gp", 32'(gameplay[0]), 0);

        // 4. miss from column 9, fire while flying is discarded
        btn_left[1] = 1'b1;
        do_tick(1, cyc);
        btn_left[1] = 1'b0;
        check("miss_ship", 32'(ship_x[1]), 9);
        press_fire(1);
        do_tick(1, cyc);
        check("miss_launch_x", 32'(bullet_x[1]), 9);
        check("miss_launch_y", 32'(bullet_y[1]), 12);
        for (int t = 3; t <= 14; t++) begin
            if (t == 5) press_fire(1);
            do_tick(1, cyc);
        end
        check("miss_top_y", 32'(bullet_y[1]), 0);
        check("miss_top_fly", 32'(flying[1]), 1);
        check("miss_top_array", 32'(inv_arr[1]), 32'h00400);
        do_tick(1, cyc);
        check("miss_end_fly", 32'(flying[1]), 0);
        check("miss_end_array", 32'(inv_arr[1]), 32'h00800);
        do_tick(1, cyc);
        check("refire_discard", 32'(flying[1]), 0);

        // 6a. win by shooting the only invader
        do_reset();
        press_fire(1);
        for (int t = 1; t <= 12; t++) do_tick(1, cyc);
        check("win_pre_gp", 32'(gameplay[1]), 0);
        do_tick(1, cyc);
        check("win_array", 32'(inv_arr[1]), 0);
        check("win_gp", 32'(gameplay[1]), 1);
        btn_right[1] = 1'b1;
        press_fire(1);
        do_tick(1, cyc);
        btn_right[1] = 1'b0;
        check("win_frozen_busy", 32'(cyc), 0);
        check("win_frozen_ship", 32'(ship_x[1]), 10);
        check("win_frozen_fly", 32'(flying[1]), 0);
        check("win_frozen_gp", 32'(gameplay[1]), 1);

        // 5. formation drops at the right edge, then steps left
        do_tick(2, cyc);
        check("drop_line", 32'(inv_line[2]), 1);
        check("drop_array", 32'(inv_arr[2]), 32'h80000);
        do_tick(2, cyc);
        check("drop_step_array", 32'(inv_arr[2]), 32'h40000);
        check("drop_step_line", 32'(inv_line[2]), 1);

        // 6b. game over when the formation reaches the ship row (tick 241)
        n = 2;
        while (gameplay[2] == 2'b00 && n < 300) begin
            do_tick(2, cyc);
            n++;
        end
        check("over_tick", 32'(n), 241);
        check("over_line", 32'(inv_line[2]), 13);
        check("over_array", 32'(inv_arr[2]), 32'h80000);
        check("over_gp", 32'(gameplay[2]), 2);
        do_tick(2, cyc);
        check("over_frozen_line", 32'(inv_line[2]), 13);
        check("over_frozen_busy", 32'(cyc), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
